// File: rtl/uart_pkg.sv
// Shared types and constants for the UART blocks (transmitter now, receiver later).
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling baud tick generator: one tick every dvsr+1 clocks while not held.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned DVSR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  output logic                  tick
);

  logic [DVSR_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    // >= rather than == so a divisor lowered mid-count cannot strand the counter.
    tick  = !hold && (cnt_q >= dvsr);
    cnt_d = (hold || tick) ? '0 : cnt_q + DVSR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a FIFO read port, 8N1 by default.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned DVSR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick
);

  localparam int unsigned S_W = $clog2(SB_TICK > OVERSAMPLE ? SB_TICK : OVERSAMPLE);
  localparam int unsigned N_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [S_W-1:0] LAST_S    = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] LAST_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] LAST_N    = N_W'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [S_W-1:0]        s_q, s_d;
  logic [N_W-1:0]        n_q, n_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  tick;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  uart_baud_gen #(
    .DVSR_WIDTH(DVSR_WIDTH)
  ) u_baud_gen (
    .clk  (clk),
    .reset(reset),
    .hold (state_q == IDLE),
    .dvsr (dvsr),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    shift_d      = shift_q;
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif

    case (state_q)
      IDLE: begin
        // Gate on reset so no pop is issued in a cycle whose edge would discard it.
        if (!fifo_empty && reset) begin
          fifo_rd = 1'b1;
          shift_d = fifo_rd_data;
          s_d     = '0;
          state_d = START;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_d = ^fifo_rd_data;
`endif
        end
      end
      START: begin
        if (tick) begin
          if (s_q == LAST_S) begin
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == LAST_S) begin
            shift_d = shift_q >> 1;
            s_d     = '0;
            if (n_q == LAST_N) begin
`ifdef FIFO_UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_q == LAST_S) begin
            state_d = STOP;
            s_d     = '0;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_q == LAST_STOP) begin
            state_d      = IDLE;
            tx_done_tick = 1'b1;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so the line tracks the state cycle-for-cycle.
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small array-backed FIFO model on the read side.
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int BITS  = 10 + PAR;
  localparam int BCLK  = 64;  // 16 * (dvsr + 1) with dvsr = 3

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] dvsr;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd;
  logic        tx;
  logic        tx_busy;
  logic        tx_done_tick;

  logic [7:0]  fifo_mem [0:7];
  logic [3:0]  wr_ptr = 4'd0;
  logic [3:0]  rd_ptr = 4'd0;
  int          cyc = 0;
  int          pops = 0;
  int          bad_pops = 0;
  int          last_pop_cyc = 0;
  int          prev_pop_cyc = 0;

  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_rd_data = fifo_mem[rd_ptr[2:0]];

  fifo_uart_tx u_dut (
    .clk         (clk),
    .reset       (reset),
    .dvsr        (dvsr),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd     (fifo_rd),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_done_tick(tx_done_tick)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd) begin
      if (fifo_empty) bad_pops <= bad_pops + 1;
      else rd_ptr <= rd_ptr + 4'd1;
      pops         <= pops + 1;
      last_pop_cyc <= cyc;
      prev_pop_cyc <= last_pop_cyc;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[2:0]] = b;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR == 1 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Leaves the caller just after the negedge of the pop cycle, or flags a timeout.
  task automatic wait_pop(input string tag);
    int t = 0;
    #1;
    while (!fifo_rd && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    check(tag, int'(fifo_rd), 1);
  endtask

  // Called in the pop cycle; cycle i after the pop belongs to frame bit (i-1)/64.
  task automatic frame_check(input logic [7:0] b, input string name);
    int good [12];
    int done_at = -1;
    int done_cnt = 0;
    int busy_cnt = 0;
    for (int k = 0; k < 12; k++) good[k] = 0;
    for (int i = 1; i <= BITS * BCLK; i++) begin
      @(negedge clk);
      if (tx == exp_bit(b, (i - 1) / BCLK)) good[(i - 1) / BCLK]++;
      if (tx_busy) busy_cnt++;
      if (tx_done_tick) begin
        done_cnt++;
        done_at = i;
      end
    end
    for (int k = 0; k < BITS; k++) check($sformatf("%s_bit%0d", name, k), good[k], BCLK);
    check({name, "_done_at"}, done_at, BITS * BCLK);
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_busy_cnt"}, busy_cnt, BITS * BCLK);
  endtask

  initial begin
    int ok;
    reset = 1'b0;
    dvsr  = 11'd3;
    push(8'h55);

    // Reset held with a non-empty FIFO.
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx && !fifo_rd && !tx_busy) ok++;
    end
    check("reset_idle", ok, 20);
    check("reset_no_pop", pops, 0);
    reset = 1'b1;
    #1;
    check("pop_after_release", int'(fifo_rd), 1);
    frame_check(8'h55, "f55");
    check("f55_pops", pops, 1);

    // Back-to-back frames.
    @(negedge clk);
    push(8'hA5);
    push(8'h3C);
    wait_pop("pop_a5");
    frame_check(8'hA5, "fa5");
    wait_pop("pop_3c");
    frame_check(8'h3C, "f3c");
    check("b2b_gap", last_pop_cyc - prev_pop_cyc, 641);
    check("b2b_pops", pops, 3);

    // Empty FIFO after a reset.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx && !fifo_rd && !tx_busy) ok++;
    end
    check("empty_idle", ok, 1000);
    check("empty_pops", pops, 3);

    // Reset in the middle of data bit 3 of 0xFF.
    push(8'hFF);
    wait_pop("pop_ff");
    for (int i = 0; i < 4 * BCLK + 32; i++) @(negedge clk);
    check("ff_mid_busy", int'(tx_busy), 1);
    push(8'h0F);
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_tx", int'(tx), 1);
    check("mid_reset_busy", int'(tx_busy), 0);
    check("mid_reset_no_pop", int'(fifo_rd), 0);
    @(negedge clk);
    reset = 1'b1;
    wait_pop("pop_0f");
    frame_check(8'h0F, "f0f");
    check("f0f_pops", pops, 5);

`ifdef FIFO_UART_TX_PARITY_EN
    @(negedge clk);
    push(8'h07);
    wait_pop("pop_07");
    frame_check(8'h07, "p07");
    @(negedge clk);
    push(8'h03);
    wait_pop("pop_03");
    frame_check(8'h03, "p03");
`endif

    @(negedge clk);
    check("no_pop_when_empty", bad_pops, 0);
    check("final_idle_tx", int'(tx), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- UART transmitter that drains the read side of an existing FIFO buffer and serialises each byte onto a single tx line (8N1 by default).
- Sits between the TX FIFO and the pad.
- Pops one entry per frame via the FIFO's rd/empty/rd_data handshake.
- Internal oversampling baud-tick generator is programmed by a divisor input.

Parameters:
- DATA_WIDTH, 8, data bits per frame and FIFO word width.
- SB_TICK, 16, stop-bit length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- DVSR_WIDTH, 11, width of the baud divisor.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- dvsr  in  DVSR_WIDTH  baud divisor; one tick every dvsr+1 clocks; baud = clk / (16*(dvsr+1)).
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_data  in  DATA_WIDTH  FIFO head word, valid combinationally while fifo_empty=0.
- fifo_rd  out  1  one-cycle pop strobe to FIFO.
- tx  out  1  serial output, idle high.
- tx_busy  out  1  high while a frame is in progress.
- tx_done_tick  out  1  one-cycle pulse at end of stop bit.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE, tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0.
  - Tick counter, bit counter and shift register cleared.
  - Applies mid-frame: tx returns to 1 at the next edge; the popped byte is dropped.
- Baud generator:
  - Counter held at 0 in IDLE; otherwise it increments each clk.
  - Counter >= dvsr: emit tick, counter <= 0. The >= compare guarantees no hang if dvsr is lowered mid-frame.
  - Frame timing is undefined if dvsr changes mid-frame.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature). Sub-bit counter s counts 0..15; bit counter n counts 0..DATA_WIDTH-1.
- IDLE:
  - tx=1.
  - If fifo_empty=0: fifo_rd=1 combinationally in this cycle, shift reg <= fifo_rd_data, s<=0, next state START.
  - fifo_rd is never asserted while fifo_empty=1 and never more than once per frame.
- START:
  - tx=0.
  - On tick: s==15 -> DATA, s<=0, n<=0; else s++.
- DATA:
  - tx = shift_reg[0] (LSB first).
  - On tick with s==15: shift right, s<=0; n==DATA_WIDTH-1 -> STOP, else n++.
  - On other ticks: s++.
- STOP:
  - tx=1.
  - On tick: s==SB_TICK-1 -> IDLE with tx_done_tick=1 for that cycle; else s++.
- tx is registered: it falls on the clock edge that ends the pop cycle.
- Each bit lasts exactly 16*(dvsr+1) clocks; stop lasts SB_TICK*(dvsr+1) clocks.
- tx_busy=1 in every state except IDLE.
- Back-to-back: if the FIFO is non-empty on return to IDLE, the next pop occurs in that first IDLE cycle. Inter-frame idle is exactly 1 clock.
- Empty FIFO: remain in IDLE indefinitely; no pop, tx=1.

Optional Feature:
- Macro FIFO_UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP, duration 16 ticks.
  - tx = even parity, the XOR of all DATA_WIDTH bits, computed when the byte is latched in IDLE.
- Undefined: DATA goes directly to STOP and no parity logic exists.

Decomposition:
- Package uart_pkg:
  - state_t enum (IDLE, START, DATA, PARITY, STOP).
  - Constant OVERSAMPLE=16.
- Sub-module uart_baud_gen:
  - Ports clk, reset, hold, dvsr, tick.
  - Implements the counter described above.
  - Reused later by the receiver.

Test Plan:
- Reset held low 20 clk with fifo_empty=0 -> tx=1, fifo_rd=0, tx_busy=0 throughout; the first pop occurs the cycle after reset is released.
- DATA_WIDTH=8, dvsr=3, SB_TICK=16, single byte 0x55:
  - Exactly one fifo_rd pulse.
  - tx low 64 clk, then bits 1,0,1,0,1,0,1,0 at 64 clk each, then high 64 clk.
  - tx_done_tick at clock 640 after the pop.
- Bytes 0xA5 then 0x3C queued, dvsr=3 -> two pops 641 clk apart; second start bit begins 1 clk after tx_done_tick; serial LSB-first patterns match.
- fifo_empty=1 for 1000 clk after reset -> fifo_rd never asserted, tx=1, tx_busy=0.
- Reset asserted during DATA bit 3 of 0xFF -> tx=1 and tx_busy=0 next edge; after release, the next queued 0x0F transmits with correct timing.
- With FIFO_UART_TX_PARITY_EN, byte 0x07, dvsr=3 -> parity bit=1 after bit 7, frame 704 clk; byte 0x03 -> parity bit=0.
